// File: rtl/core_dmem_responder.sv
// Byte-addressed data memory that answers the core's req_mem/wmem handshake.
// It self-fills byte i with i[7:0] after reset, then serves reads and masked writes after WAIT_CYCLES stall cycles.
module core_dmem_responder #(
   parameter int          DEPTH_BYTES = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_mem,
   input  logic        wmem,
   input  logic [3:0]  wmask,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        hold_i,
   output logic [31:0] data_i,
   output logic        data_stall,
   output logic        data_err,
   output logic        init_done,
   output logic [15:0] err_count
);
   localparam int AW = $clog2(DEPTH_BYTES);
   localparam logic [1:0] S_INIT = 2'd0;
   localparam logic [1:0] S_IDLE = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   logic [7:0]    mem [DEPTH_BYTES];
   logic [1:0]    state, state_nxt;
   logic [AW-1:0] ptr;
   logic [3:0]    cnt, cnt_nxt;
   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic          in_range;
   logic          respond;
   logic [31:0]   rd_word;

   // Offset wraps below BASE_ADDR to a huge value, so one compare covers both ends.
   assign off      = addr - BASE_ADDR;
   assign in_range = (off <= 32'(DEPTH_BYTES - 4));
   assign idx      = off[AW-1:0];
   assign rd_word  = {mem[idx + AW'(3)], mem[idx + AW'(2)], mem[idx + AW'(1)], mem[idx]};

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      data_stall = 1'b0;
      respond    = 1'b0;
      case (state)
         S_INIT: begin
            data_stall = req_mem;
            if (ptr == AW'(DEPTH_BYTES - 1)) state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (req_mem) begin
               if (WAIT_CYCLES == 0) begin
                  respond = 1'b1;
               end else begin
                  data_stall = 1'b1;
                  cnt_nxt    = CNT_LOAD;
                  state_nxt  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!req_mem) begin
               state_nxt = S_IDLE;
            end else if (cnt != 4'd0 || hold_i) begin
               data_stall = 1'b1;
               if (!hold_i) cnt_nxt = cnt - 4'd1;
            end else begin
               respond   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_INIT;
      endcase
   end

   assign data_err = respond && !in_range;
   assign data_i   = (respond && in_range) ? rd_word : 32'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_INIT;
         ptr       <= '0;
         cnt       <= 4'd0;
         init_done <= 1'b0;
         err_count <= 16'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == S_INIT) begin
            ptr <= ptr + AW'(1);
            if (ptr == AW'(DEPTH_BYTES - 1)) init_done <= 1'b1;
         end
         if (data_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
   end

   // Gated by reset so a write pending at reset is dropped rather than committed.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == S_INIT) begin
            mem[ptr] <= ptr[7:0];
         end else if (respond && in_range && wmem) begin
            for (int k = 0; k < 4; k++)
               if (wmask[k]) mem[idx + AW'(k)] <= wdata[8*k +: 8];
         end
      end
   end
endmodule

// File: tb/tb_core_dmem_responder.sv
// Directed bench for core_dmem_responder: three instances with WAIT_CYCLES 1, 2 and 0.
// The instances share the bus and reset, and each has its own req_mem.
module tb_core_dmem_responder;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wmem = 1'b0, hold = 1'b0;
   logic [3:0]  wmask = 4'd0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic        req [3];
   logic [31:0] dat [3];
   logic        stl [3], err [3], idn [3];
   logic [15:0] cnt [3];
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   core_dmem_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .reset(reset), .req_mem(req[0]), .wmem(wmem), .wmask(wmask), .addr(addr),
      .wdata(wdata), .hold_i(hold), .data_i(dat[0]), .data_stall(stl[0]), .data_err(err[0]),
      .init_done(idn[0]), .err_count(cnt[0]));
   core_dmem_responder #(.DEPTH_BYTES(4096), .WAIT_CYCLES(1)) u1 (
      .clk(clk), .reset(reset), .req_mem(req[1]), .wmem(wmem), .wmask(wmask), .addr(addr),
      .wdata(wdata), .hold_i(hold), .data_i(dat[1]), .data_stall(stl[1]), .data_err(err[1]),
      .init_done(idn[1]), .err_count(cnt[1]));
   core_dmem_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(2)) u2 (
      .clk(clk), .reset(reset), .req_mem(req[2]), .wmem(wmem), .wmask(wmask), .addr(addr),
      .wdata(wdata), .hold_i(hold), .data_i(dat[2]), .data_stall(stl[2]), .data_err(err[2]),
      .init_done(idn[2]), .err_count(cnt[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic wait_init(input int s);
      int n = 0;
      while (!idn[s] && n < 6000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!idn[s]) chk("init_timeout", 32'(idn[s]), 32'd1);
   endtask

   // One handshake on instance s; hold is high on stall cycles hs..hs+hl-1.
   task automatic access(input int s, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] m, input int hs, input int hl,
                         output int stalls, output logic [31:0] d, output logic e);
      logic got = 1'b0;
      wmem = w; addr = a; wdata = wd; wmask = m; req[s] = 1'b1;
      stalls = 0; d = 32'hx; e = 1'bx;
      for (int c = 0; c < 64 && !got; c++) begin
         hold = (c >= hs && c < hs + hl);
         @(negedge clk);
         if (stl[s]) stalls++;
         else begin
            d = dat[s]; e = err[s]; got = 1'b1;
         end
         @(posedge clk); #1;
      end
      req[s] = 1'b0; hold = 1'b0; wmem = 1'b0;
      if (!got) chk("access_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int          st;
      logic [31:0] d;
      logic        e;
      int          n;
      for (int i = 0; i < 3; i++) req[i] = 1'b0;

      // Reset state, with a request pending on u1 during the fill.
      req[1] = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_init_done", 32'(idn[1]), 32'd0);
      chk("rst_err_count", 32'(cnt[1]), 32'd0);
      chk("rst_data", dat[1], 32'd0);
      chk("rst_err", 32'(err[1]), 32'd0);
      chk("rst_stall_req", 32'(stl[1]), 32'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("init_stall_req", 32'(stl[1]), 32'd1);
      req[1] = 1'b0;
      #1 chk("init_stall_noreq", 32'(stl[1]), 32'd0);
      wait_init(1);
      wait_init(0);
      wait_init(2);

      // Fill pattern and upper boundary.
      access(1, 0, 32'h10, 0, 0, 0, 0, st, d, e);
      chk("rd10_data", d, 32'h13121110);
      chk("rd10_err", 32'(e), 32'd0);
      chk("rd10_stalls", 32'(st), 32'd1);
      access(1, 0, 32'hFFC, 0, 0, 0, 0, st, d, e);
      chk("rdFFC_data", d, 32'hFFFEFDFC);

      // Masked write returns old data, then readback and an unaligned read.
      access(1, 1, 32'h20, 32'hDEADBEEF, 4'b0101, 0, 0, st, d, e);
      chk("wr20_stalls", 32'(st), 32'd1);
      chk("wr20_old", d, 32'h23222120);
      access(1, 0, 32'h20, 0, 0, 0, 0, st, d, e);
      chk("rd20_new", d, 32'h23AD21EF);
      access(1, 0, 32'h21, 0, 0, 0, 0, st, d, e);
      chk("rd21_unaligned", d, 32'h2423AD21);

      // Out of range accesses.
      access(1, 0, 32'hFFD, 0, 0, 0, 0, st, d, e);
      chk("oor_rd_err", 32'(e), 32'd1);
      chk("oor_rd_data", d, 32'd0);
      chk("oor_cnt1", 32'(cnt[1]), 32'd1);
      access(1, 1, 32'h2000, 32'h55555555, 4'hF, 0, 0, st, d, e);
      chk("oor_wr_err", 32'(e), 32'd1);
      chk("oor_cnt2", 32'(cnt[1]), 32'd2);
      access(1, 0, 32'h0, 0, 0, 0, 0, st, d, e);
      chk("oor_wr_nowrite", d, 32'h03020100);
      access(1, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, st, d, e);
      chk("oor_wrap_err", 32'(e), 32'd1);
      chk("oor_cnt3", 32'(cnt[1]), 32'd3);

      // Backpressure on u2: two wait stalls plus three hold cycles.
      access(2, 0, 32'h10, 0, 0, 1, 3, st, d, e);
      chk("hold_stalls", 32'(st), 32'd5);
      chk("hold_data", d, 32'h13121110);

      // Flush: drop req_mem during WAIT of a write.
      wmem = 1'b1; addr = 32'h30; wdata = 32'hFFFFFFFF; wmask = 4'hF; req[2] = 1'b1;
      @(negedge clk);
      chk("flush_stall_idle", 32'(stl[2]), 32'd1);
      @(posedge clk); #1;
      req[2] = 1'b0; wmem = 1'b0;
      @(negedge clk);
      chk("flush_stall_low", 32'(stl[2]), 32'd0);
      chk("flush_err", 32'(err[2]), 32'd0);
      @(posedge clk); #1;
      access(2, 0, 32'h30, 0, 0, 0, 0, st, d, e);
      chk("flush_nowrite", d, 32'h33323130);
      chk("flush_stalls", 32'(st), 32'd2);
      chk("flush_cnt", 32'(cnt[2]), 32'd0);

      // Back-to-back reads with no wait states.
      req[0] = 1'b1; wmem = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] b;
         b = 8'(4 * i);
         addr = 32'(4 * i);
         @(negedge clk);
         chk("b2b_stall", 32'(stl[0]), 32'd0);
         chk("b2b_data", dat[0], {b + 8'd3, b + 8'd2, b + 8'd1, b});
         @(posedge clk); #1;
      end
      req[0] = 1'b0;

      // Reset while a write to 0x40 sits in WAIT.
      wmem = 1'b1; addr = 32'h40; wdata = 32'h0; wmask = 4'hF; req[1] = 1'b1;
      @(negedge clk);
      chk("rstw_stall", 32'(stl[1]), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1; req[1] = 1'b0; wmem = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstw_cnt_clr", 32'(cnt[1]), 32'd0);
      wait_init(1);
      access(1, 0, 32'h40, 0, 0, 0, 0, st, d, e);
      chk("rstw_nowrite", d, 32'h43424140);

      // Reset mid-fill restarts the full fill.
      pulse_reset();
      repeat (100) @(posedge clk);
      #1 pulse_reset();
      n = 0;
      while (n < 4095) begin
         @(posedge clk); #1;
         n++;
         if (idn[1]) break;
      end
      chk("refill_early", 32'(idn[1]), 32'd0);
      @(posedge clk); #1;
      chk("refill_done", 32'(idn[1]), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/core_dmem_responder.md
Name: core_dmem_responder

Overview:
- Synthesizable data-memory responder for the core's data port: the slave end of the req_mem/wmem/wmask/addr/data handshake.
- Returns read data, stretches accesses with data_stall, flags bad accesses with data_err, and commits byte-masked writes.
- After reset it self-initialises byte i to i[7:0], so existing directed tests run unchanged against RTL memory.
- Sits beside the core in SoC-level and FPGA builds.

Parameters:
- DEPTH_BYTES, 4096: memory size in bytes; power of two, >= 4.
- BASE_ADDR, 32'h0000_0000: byte address of memory[0].
- WAIT_CYCLES, 1: stall cycles inserted before each response; 0..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_mem  input  1  core data request, held with address/data until data_stall is low.
- wmem  input  1  1 = write, 0 = read; qualified by req_mem.
- wmask  input  4  byte enables for addr+0..addr+3; writes only.
- addr  input  32  byte address.
- wdata  input  32  write data; byte k goes to addr+k.
- hold_i  input  1  extra backpressure; freezes the wait counter.
- data_i  output  32  read data, {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
- data_stall  output  1  response not ready.
- data_err  output  1  access error, valid in the response cycle.
- init_done  output  1  initialisation fill complete.
- err_count  output  16  saturating count of errored responses.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous, active-high.
- Reset values: state=INIT, fill pointer=0, wait counter=0, data_stall=req_mem, data_err=0, data_i=0, init_done=0, err_count=0.
- States: INIT, IDLE, WAIT.
- INIT:
  - Each cycle writes mem[ptr]=ptr[7:0] and increments ptr.
  - After writing DEPTH_BYTES-1, go to IDLE; init_done=1 from the next cycle onward.
  - data_stall=req_mem; requests are neither accepted nor written.
  - Reset in INIT restarts the fill at 0.
- Range check: off = addr - BASE_ADDR as unsigned 32-bit. The access is in range iff off <= DEPTH_BYTES-4, so all four bytes are inside. Unaligned in-range accesses are legal. Wrap-around below BASE_ADDR counts as out of range.
- Response cycle: a cycle with req_mem=1 and data_stall=0.
  - In range, read: data_i = 4 bytes at off (little-endian).
  - In range, write: at that clock edge, bytes with wmask[k]=1 are written from wdata[8k+7:8k]; data_i = pre-write contents.
  - Out of range: data_err=1, data_i=0, no write, err_count += 1, saturating at 16'hFFFF.
  - Outside a response cycle: data_i=0 and data_err=0.
- IDLE:
  - req_mem=0: stall=0.
  - req_mem=1 and WAIT_CYCLES=0: respond this cycle, stay in IDLE.
  - req_mem=1 and WAIT_CYCLES>0: data_stall=1, cnt<=WAIT_CYCLES-1, go to WAIT.
- WAIT:
  - data_stall=1 while cnt!=0 or hold_i=1; cnt decrements only when hold_i=0.
  - cnt=0 and hold_i=0: response cycle, then go to IDLE.
  - Total latency is WAIT_CYCLES stalled cycles plus hold_i cycles, then the response.
  - req_mem=0 in WAIT (core flush): abandon and go to IDLE next cycle; stall=0, no write, no err_count change.
- Back-to-back: req_mem held high after a response cycle is a new request, evaluated in IDLE the next cycle. With WAIT_CYCLES=0, one access completes per cycle.
- hold_i in IDLE or INIT has no effect.
- Reset mid-WAIT: the pending write is discarded and the memory is refilled.
- Core-side protocol: addr/wdata/wmask/wmem changing while stalled is a core error. The responder uses the values present in the response cycle.

Test Plan:
- Init fill: reset 1 cycle, wait for init_done. Then read addr=0x10 → data_i=0x13121110, err=0. Read 0xFFC → 0xFFFEFDFC. The first request needs DEPTH_BYTES cycles after reset.
- Write/readback with WAIT_CYCLES=1:
  - Write addr=0x20, wdata=0xDEADBEEF, wmask=4'b0101 → exactly 1 stall cycle; the response cycle shows old data 0x23222120.
  - Read 0x20 → 0x23AD21EF.
- Out of range: read 0xFFD (DEPTH 4096) → data_err=1, data_i=0, err_count=1. Write 0x2000 → err=1, memory unchanged, err_count=2.
- Backpressure: WAIT_CYCLES=2 with hold_i high for 3 cycles mid-wait → exactly 5 stalled cycles, then a correct response. Drop req_mem during WAIT → stall low, no write.
- Back-to-back with WAIT_CYCLES=0: 4 consecutive reads 0x0,0x4,0x8,0xC → zero stall cycles, data 0x03020100 through 0x0F0E0D0C.
- Reset mid-operation:
  - Reset during WAIT of a write to 0x40 → write not committed; after refill, read 0x40 → 0x43424140.
  - Reset mid-INIT → init_done stays low for a full DEPTH_BYTES cycles after the last reset.
